// File: rtl/iir_pkg.sv
// Shared constants and types for the iir_cascade filter and its output capture path.
package iir_pkg;

    localparam int unsigned IIR_DWIDTH        = 24;
    localparam int unsigned IIR_CWIDTH        = 18;
    localparam int unsigned IIR_CASCADE_LEVEL = 4;
    // Settle time that matches the existing checker timing
    localparam int unsigned IIR_SETTLE_DEF    = 15;

    typedef enum logic {
        StIdle = 1'b0,
        StWait = 1'b1
    } cap_state_e;

endpackage

// File: rtl/iir_cap_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; DEPTH must be a power of two.
module iir_cap_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;
    assign pop_ok  = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees the head slot on the same edge
    assign push_ok = push & (~full | pop_ok);
    assign dout    = empty ? '0 : mem[rd_q];

    always_comb begin
        level_d = level_q;
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop_ok)  rd_q <= rd_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_q] <= din;
    end

endmodule

// File: rtl/iir_dout_capture.sv
// Samples iir_cascade dout a programmable time after din_vld and streams it out
// through a small FIFO, flagging overruns, overflows and lost samples.
module iir_dout_capture
    import iir_pkg::*;
#(
    parameter int unsigned DWIDTH     = IIR_DWIDTH,
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DROP_W     = 8,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              block_en,
    input  logic [CNT_W-1:0]  settle_cyc,
    input  logic              din_vld,
    input  logic [DWIDTH-1:0] iir_dout,
    input  logic              err_clr,
    output logic              out_vld,
    output logic [DWIDTH-1:0] out_data,
    input  logic              out_rdy,
    output logic [LVL_W-1:0]  fifo_lvl,
    output logic              ovr_err,
    output logic              ovf_err,
    output logic [DROP_W-1:0] drop_cnt
);

    cap_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] settle_ld;
    logic             fifo_full, fifo_empty;
    logic             overrun, cap_due, overflow, drop;

    assign settle_ld = (settle_cyc == '0) ? CNT_W'(1) : settle_cyc;
    assign overrun   = block_en & din_vld & (state_q == StWait);
    assign cap_due   = block_en & ~din_vld & (state_q == StWait) & (cnt_q == CNT_W'(1));
    assign overflow  = cap_due & fifo_full & ~out_rdy;
    // Overrun and overflow are mutually exclusive, so at most one sample is lost per edge
    assign drop      = overrun | overflow;
    assign out_vld   = ~fifo_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else if (!block_en) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (din_vld) begin
                        cnt_q   <= settle_ld;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (din_vld) begin
                        cnt_q <= settle_ld;
                    end else if (cnt_q == CNT_W'(1)) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovr_err  <= 1'b0;
            ovf_err  <= 1'b0;
            drop_cnt <= '0;
        end else if (err_clr) begin
            ovr_err  <= 1'b0;
            ovf_err  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (overrun)  ovr_err <= 1'b1;
            if (overflow) ovf_err <= 1'b1;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

    iir_cap_fifo #(
        .WIDTH (DWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (~block_en),
        .push  (cap_due),
        .pop   (out_rdy),
        .din   (iir_dout),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_lvl)
    );

endmodule

// File: tb/tb_iir_dout_capture.sv
// Bench for iir_dout_capture: directed sequences, a latency table and a random run
// compared cycle by cycle against a pending-capture/queue reference model.
module tb_iir_dout_capture;

    localparam int unsigned DW    = 24;
    localparam int unsigned CW    = 6;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DROPW = 8;
    localparam int unsigned LW    = 3;

    logic             clk = 1'b0;
    logic             rstn, block_en, din_vld, err_clr, out_rdy;
    logic [CW-1:0]    settle_cyc;
    logic [DW-1:0]    iir_dout;
    logic             out_vld, ovr_err, ovf_err;
    logic [DW-1:0]    out_data;
    logic [LW-1:0]    fifo_lvl;
    logic [DROPW-1:0] drop_cnt;

    iir_dout_capture #(
        .DWIDTH     (DW),
        .CNT_W      (CW),
        .FIFO_DEPTH (DEPTH),
        .DROP_W     (DROPW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .block_en   (block_en),
        .settle_cyc (settle_cyc),
        .din_vld    (din_vld),
        .iir_dout   (iir_dout),
        .err_clr    (err_clr),
        .out_vld    (out_vld),
        .out_data   (out_data),
        .out_rdy    (out_rdy),
        .fifo_lvl   (fifo_lvl),
        .ovr_err    (ovr_err),
        .ovf_err    (ovf_err),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: a pending capture due at an absolute edge, plus a queue for the FIFO
    logic [DW-1:0] m_q[$];
    bit            m_pend = 1'b0;
    int            m_cap  = 0;
    bit            m_ovr  = 1'b0;
    bit            m_ovf  = 1'b0;
    int            m_drop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_pend = 1'b0;
        m_ovr  = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endfunction

    function automatic void model_step();
        bit pop, lost, was_full;
        if (!rstn) begin
            model_reset();
            return;
        end
        if (!block_en) begin
            m_pend = 1'b0;
            m_q.delete();
        end else begin
            lost     = 1'b0;
            was_full = (m_q.size() == DEPTH);
            pop      = (m_q.size() != 0) && out_rdy;
            if (pop) void'(m_q.pop_front());
            if (din_vld) begin
                if (m_pend) begin
                    m_ovr = 1'b1;
                    lost  = 1'b1;
                end
                m_pend = 1'b1;
                m_cap  = cyc + ((settle_cyc == 0) ? 1 : int'(settle_cyc));
            end else if (m_pend && cyc == m_cap) begin
                m_pend = 1'b0;
                if (!was_full || pop) m_q.push_back(iir_dout);
                else begin
                    m_ovf = 1'b1;
                    lost  = 1'b1;
                end
            end
            if (lost && m_drop < 255) m_drop++;
        end
        if (err_clr) begin
            m_ovr  = 1'b0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end
    endfunction

    task automatic tick();
        logic [37:0] act, exp;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        act = {out_vld, fifo_lvl, out_data, ovr_err, ovf_err, drop_cnt};
        exp = {m_q.size() != 0, LW'(m_q.size()), (m_q.size() != 0) ? m_q[0] : DW'(0),
               m_ovr, m_ovf, DROPW'(m_drop)};
        check("model", act, exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe();
        din_vld = 1'b1;
        tick();
        din_vld = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    typedef struct {
        logic [CW-1:0] settle;
        logic [DW-1:0] data;
        int            lat;
    } vec_t;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[6];
        logic [DW-1:0] gold[$];
        int            lat, n_out;

        tbl[0] = '{settle: 6'd15, data: 24'h0A1B2C, lat: 15};
        tbl[1] = '{settle: 6'd0,  data: 24'hFFFFFF, lat: 1};
        tbl[2] = '{settle: 6'd1,  data: 24'h800000, lat: 1};
        tbl[3] = '{settle: 6'd2,  data: 24'h000001, lat: 2};
        tbl[4] = '{settle: 6'd7,  data: 24'h5A5A5A, lat: 7};
        tbl[5] = '{settle: 6'd63, data: 24'hC0FFEE, lat: 63};

        rstn = 1'b0; block_en = 1'b1; din_vld = 1'b0; err_clr = 1'b0; out_rdy = 1'b0;
        settle_cyc = 6'd15; iir_dout = '0;
        ticks(2);
        check("reset", {out_vld, fifo_lvl, out_data, ovr_err, ovf_err, drop_cnt}, '0);
        rstn = 1'b1;
        tick();

        // Basic capture: data only becomes valid 10 edges after the strobe
        out_rdy = 1'b1; iir_dout = 24'hABCDEF;
        strobe();
        for (int k = 1; k < 15; k++) begin
            if (k == 10) iir_dout = 24'h012345;
            tick();
        end
        check("basic_early", out_vld, 1'b0);
        tick();
        check("basic_vld", out_vld, 1'b1);
        check("basic_data", out_data, 24'h012345);
        check("basic_flags", {ovr_err, ovf_err, drop_cnt}, '0);
        tick();
        check("basic_single", {out_vld, fifo_lvl}, '0);

        // Overrun: strobes at relative edges 0 and 10, single capture at 25
        iir_dout = 24'h0BEEF1;
        strobe();
        ticks(9);
        strobe();
        ticks(14);
        check("ovr_early", out_vld, 1'b0);
        tick();
        check("ovr_vld", {out_vld, out_data}, {1'b1, 24'h0BEEF1});
        check("ovr_flags", {ovr_err, ovf_err, drop_cnt}, {1'b1, 1'b0, 8'd1});
        tick();
        check("ovr_single", out_vld, 1'b0);
        pulse_clr();
        check("ovr_clr", {ovr_err, drop_cnt}, '0);

        // Backpressure: six captures into a four-deep FIFO
        out_rdy = 1'b0; settle_cyc = 6'd3;
        for (int i = 0; i < 6; i++) begin
            iir_dout = 24'h100000 + 24'(i);
            strobe();
            ticks(5);
        end
        check("ovf_lvl", fifo_lvl, 3'd4);
        check("ovf_flags", {ovr_err, ovf_err, drop_cnt}, {1'b0, 1'b1, 8'd2});
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain", {out_vld, out_data}, {1'b1, 24'h100000 + 24'(i)});
            tick();
        end
        check("ovf_empty", out_vld, 1'b0);
        out_rdy = 1'b0;
        pulse_clr();

        // Full FIFO with capture and pop on the same edge
        for (int i = 0; i < 4; i++) begin
            iir_dout = 24'h200000 + 24'(i);
            strobe();
            ticks(5);
        end
        iir_dout = 24'h200004;
        strobe();
        ticks(2);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        check("fullpop_lvl", fifo_lvl, 3'd4);
        check("fullpop_flags", {ovf_err, drop_cnt}, '0);
        out_rdy = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check("fullpop_drain", out_data, 24'h200000 + 24'(i));
            tick();
        end
        out_rdy = 1'b0;

        // Flush during WAIT with three entries queued and an overrun recorded
        iir_dout = 24'h300000;
        strobe();
        strobe();
        ticks(3);
        for (int i = 0; i < 2; i++) begin
            iir_dout = 24'h300001 + 24'(i);
            strobe();
            ticks(4);
        end
        check("flush_pre", fifo_lvl, 3'd3);
        strobe();
        tick();
        block_en = 1'b0; din_vld = 1'b1;
        tick();
        block_en = 1'b1; din_vld = 1'b0;
        check("flush", {out_vld, fifo_lvl, ovr_err, ovf_err, drop_cnt},
              {1'b0, 3'd0, 1'b1, 1'b0, 8'd1});
        ticks(5);
        check("flush_nocap", fifo_lvl, 3'd0);
        pulse_clr();

        // Latency table; settle_cyc is disturbed after the strobe to show it is sampled once
        for (int v = 0; v < 6; v++) begin
            iir_dout   = tbl[v].data;
            settle_cyc = tbl[v].settle;
            strobe();
            settle_cyc = ~tbl[v].settle;
            lat = -1;
            for (int k = 1; k <= tbl[v].lat + 4; k++) begin
                tick();
                if (out_vld) begin
                    lat = k;
                    break;
                end
            end
            check("tbl_lat", lat, tbl[v].lat);
            check("tbl_data", out_data, tbl[v].data);
            out_rdy = 1'b1;
            tick();
            out_rdy = 1'b0;
        end

        // Stream at bench cadence
        settle_cyc = 6'd15; out_rdy = 1'b1; n_out = 0;
        for (int i = 0; i < 64; i++) begin
            iir_dout = DW'($urandom);
            gold.push_back(iir_dout);
            strobe();
            for (int k = 0; k < 31; k++) begin
                tick();
                if (out_vld) begin
                    n_out++;
                    check("stream_data", out_data, (gold.size() != 0) ? gold.pop_front() : 'x);
                end
            end
        end
        check("stream_count", n_out, 64);
        check("stream_drop", drop_cnt, 8'd0);

        // Asynchronous reset mid-WAIT with an entry queued and a flag set
        out_rdy = 1'b0; settle_cyc = 6'd1;
        strobe();
        tick();
        settle_cyc = 6'd15;
        strobe();
        strobe();
        ticks(3);
        check("arst_pre", {out_vld, ovr_err}, 2'b11);
        #2;
        rstn = 1'b0;
        #1;
        check("arst", {out_vld, fifo_lvl, out_data, ovr_err, ovf_err, drop_cnt}, '0);
        model_reset();
        tick();
        rstn = 1'b1;
        tick();

        // Random run with rising backpressure per epoch
        for (int e = 0; e < 4; e++) begin
            for (int i = 0; i < 600; i++) begin
                block_en   = ($urandom_range(0, 99) != 0);
                din_vld    = ($urandom_range(0, 9) == 0);
                out_rdy    = ($urandom_range(0, 3) >= e);
                err_clr    = ($urandom_range(0, 199) == 0);
                settle_cyc = CW'($urandom_range(0, 12));
                iir_dout   = DW'($urandom);
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
